// File: rtl/ft_fifo_pkg.sv
// Shared encodings and helpers for the FT601 FIFO-side responder.
package ft_fifo_pkg;
    localparam int FT_DATA_W = 32;
    localparam int FT_BE_W   = 4;
    localparam int FT_WORD_W = FT_DATA_W + FT_BE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_TURN  = 2'd2,
        S_READ  = 2'd3
    } ft_state_e;

    function automatic logic [2:0] popcount4(input logic [FT_BE_W-1:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/ft_resp_mem.sv
// Word buffer for the responder: synchronous write, asynchronous (fall-through) read.
module ft_resp_mem
    import ft_fifo_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [FT_WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [FT_WORD_W-1:0] rdata
);
    logic [FT_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ft_fifo_responder.sv
// FT601 245-sync FIFO-chip emulation: buffers master writes and returns them on master reads.
//  state   | meaning
//  S_IDLE  | bus released, waiting for wr_n or oe_n
//  S_WRITE | master drives bus, words accepted while txe_n=0
//  S_TURN  | one-cycle turnaround, bus enable registered
//  S_READ  | responder drives head word, reads accepted while rxf_n=0
module ft_fifo_responder
    import ft_fifo_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 usb_clk,
    input  logic                 rst,
    input  logic                 wr_n,
    input  logic                 rd_n,
    input  logic                 oe_n,
    output logic                 txe_n,
    output logic                 rxf_n,
    inout  wire  [FT_DATA_W-1:0] data,
    inout  wire  [FT_BE_W-1:0]   be,
    output logic [ADDR_W:0]      level,
    output logic [31:0]          bytes_in,
    output logic [31:0]          bytes_out,
    output logic                 ovf_err,
    output logic                 unf_err,
    output logic                 proto_err
);
    ft_state_e            state, state_next;
    logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
    logic [ADDR_W:0]      level_next;
    logic                 drv_en;
    logic                 wr_acc, rd_acc, ovf_set, unf_set, proto_set;
    logic [FT_WORD_W-1:0] head_word, last_word, out_word;

    ft_resp_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (usb_clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata ({be, data}),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // An IDLE strobe only opens the write phase; words are taken in S_WRITE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!wr_n && oe_n)      state_next = S_WRITE;
                else if (!oe_n && wr_n) state_next = S_TURN;
            end
            S_WRITE: if (wr_n) state_next = S_IDLE;
            S_TURN:  state_next = S_READ;
            S_READ:  if (oe_n) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        proto_set = !wr_n && !oe_n;
        case (state)
            S_WRITE: if (!wr_n && oe_n) begin
                if (!txe_n) wr_acc  = 1'b1;
                else        ovf_set = 1'b1;
            end
            S_READ: if (!rd_n) begin
                if (!rxf_n) rd_acc  = 1'b1;
                else        unf_set = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        level_next = level;
        if (wr_acc)      level_next = level + (ADDR_W+1)'(1);
        else if (rd_acc) level_next = level - (ADDR_W+1)'(1);
    end

    always_ff @(posedge usb_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            txe_n     <= 1'b1;
            rxf_n     <= 1'b1;
            drv_en    <= 1'b0;
            last_word <= '0;
            bytes_in  <= '0;
            bytes_out <= '0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            level  <= level_next;
            txe_n  <= (level_next == (ADDR_W+1)'(DEPTH));
            rxf_n  <= (level_next == '0);
            drv_en <= (state_next == S_READ);
            if (wr_acc) begin
                wr_ptr   <= wr_ptr + ADDR_W'(1);
                bytes_in <= bytes_in + 32'(popcount4(be));
            end
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                last_word <= head_word;
                bytes_out <= bytes_out + 32'(popcount4(head_word[FT_WORD_W-1:FT_DATA_W]));
            end
            if (ovf_set)   ovf_err   <= 1'b1;
            if (unf_set)   unf_err   <= 1'b1;
            if (proto_set) proto_err <= 1'b1;
        end
    end

    // Once drained, keep presenting the last word returned rather than a stale slot.
    assign out_word = rxf_n ? last_word : head_word;
    assign data = drv_en ? out_word[FT_DATA_W-1:0] : 'z;
    assign be   = drv_en ? out_word[FT_WORD_W-1:FT_DATA_W] : 'z;
endmodule

// File: tb/tb_ft_fifo_responder.sv
// Directed bench for ft_fifo_responder with DEPTH=8.
module tb_ft_fifo_responder;
    import ft_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic        usb_clk = 1'b0;
    logic        rst;
    logic        wr_n, rd_n, oe_n;
    logic        txe_n, rxf_n;
    wire  [31:0] data;
    wire  [3:0]  be;
    logic [3:0]  level;
    logic [31:0] bytes_in, bytes_out;
    logic        ovf_err, unf_err, proto_err;

    logic        m_drv;
    logic [31:0] m_data;
    logic [3:0]  m_be;

    int n_cmp = 0;
    int n_err = 0;

    assign data = m_drv ? m_data : 'z;
    assign be   = m_drv ? m_be   : 'z;

    always #5 usb_clk = ~usb_clk;

    ft_fifo_responder #(.DEPTH(DEPTH)) dut (
        .usb_clk   (usb_clk),
        .rst       (rst),
        .wr_n      (wr_n),
        .rd_n      (rd_n),
        .oe_n      (oe_n),
        .txe_n     (txe_n),
        .rxf_n     (rxf_n),
        .data      (data),
        .be        (be),
        .level     (level),
        .bytes_in  (bytes_in),
        .bytes_out (bytes_out),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .proto_err (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic bus_idle();
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        oe_n  = 1'b1;
        m_drv = 1'b0;
    endtask

    task automatic apply_reset();
        bus_idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Opening strobe cycle, then one word per cycle, then release.
    task automatic write_word_start(input logic [31:0] d, input logic [3:0] b);
        m_drv = 1'b1; m_data = d; m_be = b; wr_n = 1'b0;
        tick();
    endtask

    task automatic write_word(input logic [31:0] d, input logic [3:0] b);
        m_drv = 1'b1; m_data = d; m_be = b; wr_n = 1'b0;
        tick();
    endtask

    task automatic write_end();
        wr_n = 1'b1; m_drv = 1'b0;
        tick();
    endtask

    task automatic enter_read();
        oe_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic leave_read();
        rd_n = 1'b1; oe_n = 1'b1;
        tick();
    endtask

    logic [31:0] lb [4];

    initial begin
        lb[0] = 32'h1111_1111; lb[1] = 32'h2222_2222;
        lb[2] = 32'h3333_3333; lb[3] = 32'h4444_4444;
        bus_idle();
        m_data = '0; m_be = '0;
        rst = 1'b0;
        #12;
        check("rst_txe_n", 32'(txe_n), 32'd1);
        check("rst_rxf_n", 32'(rxf_n), 32'd1);
        check("rst_drv_en", 32'(dut.drv_en), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("rel_txe_n", 32'(txe_n), 32'd0);
        check("rel_rxf_n", 32'(rxf_n), 32'd1);
        check("rel_level", 32'(level), 32'd0);

        // Loopback of four full words
        write_word_start(lb[0], 4'hF);
        for (int i = 0; i < 4; i++) write_word(lb[i], 4'hF);
        write_end();
        check("lb_level", 32'(level), 32'd4);
        check("lb_rxf_n", 32'(rxf_n), 32'd0);
        check("lb_bytes_in", bytes_in, 32'd16);
        enter_read();
        check("lb_drv_en", 32'(dut.drv_en), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lb_data%0d", i), data, lb[i]);
            rd_n = 1'b0;
            tick();
        end
        check("lb_rxf_after", 32'(rxf_n), 32'd1);
        check("lb_bytes_out", bytes_out, 32'd16);
        leave_read();
        check("lb_release", 32'(dut.drv_en), 32'd0);
        check("lb_state", 32'(dut.state), 32'(S_IDLE));

        // Fill to DEPTH, overflow, drain, then underflow
        apply_reset();
        write_word_start(32'hA000_0000, 4'hF);
        for (int i = 0; i < DEPTH; i++) begin
            write_word(32'hA000_0000 + 32'(i), 4'hF);
            if (i == DEPTH - 2) check("full_txe_pre", 32'(txe_n), 32'd0);
        end
        check("full_txe_n", 32'(txe_n), 32'd1);
        check("full_level", 32'(level), 32'd8);
        check("full_ovf_pre", 32'(ovf_err), 32'd0);
        write_word(32'hDEAD_BEEF, 4'hF);
        write_end();
        check("ovf_err", 32'(ovf_err), 32'd1);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_bytes_in", bytes_in, 32'd32);
        enter_read();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("full_data%0d", i), data, 32'hA000_0000 + 32'(i));
            rd_n = 1'b0;
            tick();
        end
        check("drain_level", 32'(level), 32'd0);
        check("unf_pre", 32'(unf_err), 32'd0);
        rd_n = 1'b0;
        tick();
        check("unf_err", 32'(unf_err), 32'd1);
        check("unf_level", 32'(level), 32'd0);
        check("unf_hold", data, 32'hA000_0007);
        check("unf_bytes_out", bytes_out, 32'd32);
        leave_read();

        // Partial byte enables
        apply_reset();
        write_word_start(32'hAABB_CCDD, 4'b0011);
        write_word(32'hAABB_CCDD, 4'b0011);
        write_end();
        check("pbe_bytes_in", bytes_in, 32'd2);
        enter_read();
        check("pbe_data", data, 32'hAABB_CCDD);
        check("pbe_be", 32'(be), 32'h3);
        rd_n = 1'b0;
        tick();
        check("pbe_bytes_out", bytes_out, 32'd2);
        leave_read();

        // wr_n and oe_n together in IDLE
        check("proto_pre", 32'(proto_err), 32'd0);
        wr_n = 1'b0; oe_n = 1'b0;
        tick();
        check("proto_err", 32'(proto_err), 32'd1);
        check("proto_level", 32'(level), 32'd0);
        check("proto_state", 32'(dut.state), 32'(S_IDLE));
        check("proto_drv_en", 32'(dut.drv_en), 32'd0);
        bus_idle();
        tick();

        // Asynchronous reset in the middle of a read
        apply_reset();
        write_word_start(32'h0000_0001, 4'hF);
        for (int i = 1; i <= 3; i++) write_word(32'(i), 4'hF);
        write_end();
        enter_read();
        check("mid_level", 32'(level), 32'd3);
        check("mid_drv_en", 32'(dut.drv_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_drv_en", 32'(dut.drv_en), 32'd0);
        check("mid_rst_rxf_n", 32'(rxf_n), 32'd1);
        check("mid_rst_txe_n", 32'(txe_n), 32'd1);
        bus_idle();
        tick();
        rst = 1'b1;
        tick();
        check("post_level", 32'(level), 32'd0);
        check("post_rxf_n", 32'(rxf_n), 32'd1);
        check("post_txe_n", 32'(txe_n), 32'd0);
        check("post_state", 32'(dut.state), 32'(S_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
